uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/parity_d.sv | 19 +
 rtl/uart_tx_serializer.sv | 135 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive slice: frame states,
// parity selectors and the width helper used to size bit-time counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Bits needed to hold values 0..value-1; never below 1 so counters stay legal.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/parity_d.sv
// Parity generator shared by the TX and RX paths; combinational, so callers
// register the result wherever the word is captured.
module parity_d
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_TYPE = 0
) (
  input  logic [DATA_BITS-1:0] data,
  output logic                 parity
);

  logic odd_sel;

  assign odd_sel = (PARITY_TYPE == int'(PARITY_ODD));
  assign parity  = (PARITY_EN != 0) ? ((^data) ^ odd_sel) : 1'b0;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, LSB-first data, optional parity, stop
// bit(s). Bit timing comes from an internal cycle counter.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_TYPE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int IDX_W = clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 parity_w;
  logic                 bit_done;

  parity_d #(
    .DATA_BITS  (DATA_BITS),
    .PARITY_EN  (PARITY_EN),
    .PARITY_TYPE(PARITY_TYPE)
  ) u_parity (
    .data  (data_in),
    .parity(parity_w)
  );

  assign tx_ready = (state_reg == IDLE);
  assign tx_busy  = (state_reg != IDLE);
  assign bit_done = (cnt_reg == CNT_LAST);
  assign tx_done  = (state_reg == STOP) && bit_done && (bit_idx_reg == STOP_LAST);
  assign tx       = tx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    cnt_next     = (state_reg == IDLE || bit_done) ? '0 : cnt_reg + CNT_W'(1);

    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          state_next   = START;
          shift_next   = data_in;
          parity_next  = parity_w;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_reg == DATA_LAST) begin
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
            shift_next   = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_next   = STOP;
          bit_idx_next = '0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_idx_reg == STOP_LAST) begin
            state_next   = IDLE;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is a function of where the frame will be next cycle, so tx
  // is registered without adding a cycle of latency to any bit.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parameterisations, each compared every
// cycle against a position-in-frame model, plus literal frame checks.
module tb_uart_tx_serializer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      valid_v = '0;
  logic [2:0][8:0] data_v = '0;
  logic [2:0]      tx_v, ready_v, busy_v, done_v;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int cpb_of(input int k);
    return (k == 1) ? 4 : 16;
  endfunction

  // Instance 0: defaults. Instance 1: odd parity, 2 stop bits, 4 clk/bit.
  // Instance 2: no parity, 1 stop bit, 16 clk/bit.
  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int DB  = 8;
    localparam int PE  = (gi == 2) ? 0 : 1;
    localparam int PT  = (gi == 1) ? 1 : 0;
    localparam int SB  = (gi == 1) ? 2 : 1;
    localparam int CPB = (gi == 1) ? 4 : 16;
    localparam int LEN = (1 + DB + PE + SB) * CPB;

    int         m_pos = -1;
    logic [7:0] m_word = '0;

    uart_tx_serializer #(
      .DATA_BITS   (DB),
      .PARITY_EN   (PE),
      .PARITY_TYPE (PT),
      .STOP_BITS   (SB),
      .CLKS_PER_BIT(CPB)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_valid(valid_v[gi]),
      .tx_ready(ready_v[gi]),
      .data_in (data_v[gi][7:0]),
      .tx      (tx_v[gi]),
      .tx_busy (busy_v[gi]),
      .tx_done (done_v[gi])
    );

    // Model: -1 when idle, otherwise the cycle number within the frame.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_pos <= -1;
      end else if (m_pos < 0) begin
        if (valid_v[gi]) begin
          m_pos  <= 0;
          m_word <= data_v[gi][7:0];
        end
      end else if (m_pos == LEN - 1) begin
        m_pos <= -1;
      end else begin
        m_pos <= m_pos + 1;
      end
    end

    function automatic logic line_bit(input int pos, input logic [7:0] w);
      int b;
      b = pos / CPB;
      if (b == 0) return 1'b0;
      if (b <= DB) return w[b-1];
      if (PE != 0 && b == DB + 1) return (^w) ^ (PT != 0);
      return 1'b1;
    endfunction

    always @(negedge clk) begin
      if (chk_en) begin
        logic e_tx;
        e_tx = (m_pos < 0) ? 1'b1 : line_bit(m_pos, m_word);
        chk1($sformatf("tx[%0d]", gi), tx_v[gi], e_tx);
        chk1($sformatf("ready[%0d]", gi), ready_v[gi], m_pos < 0);
        chk1($sformatf("busy[%0d]", gi), busy_v[gi], m_pos >= 0);
        chk1($sformatf("done[%0d]", gi), done_v[gi], m_pos == LEN - 1);
        if (done_v[gi])
          $display("inst %0d: frame of %0d cycles sent, word 0x%02h", gi, LEN, m_word);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word, samples the line mid-bit, measures frame length. A valid
  // pulse of 0xFF is injected at frame cycle inj (disabled when inj < 0).
  task automatic send_frame(input int k, input logic [7:0] d, input int inj,
                            input int exp_len, input logic [15:0] exp_bits,
                            input int nbits, input string name);
    int          len;
    int          idx;
    logic [15:0] bits;
    logic [15:0] mask;
    logic        seen;
    len  = 0;
    idx  = 0;
    bits = '0;
    seen = 1'b0;
    mask = 16'((1 << nbits) - 1);
    valid_v[k] = 1'b1;
    data_v[k]  = {1'b0, d};
    step();
    valid_v[k] = 1'b0;
    chk1({name, "_start"}, tx_v[k], 1'b0);
    for (int c = 0; c < 400; c++) begin
      if (inj >= 0 && len == inj) begin
        valid_v[k] = 1'b1;
        data_v[k]  = 9'h0FF;
        chk1({name, "_ready_mid"}, ready_v[k], 1'b0);
      end else if (inj >= 0 && len == inj + 1) begin
        valid_v[k] = 1'b0;
      end
      if ((len % cpb_of(k)) == cpb_of(k) / 2 && idx < 16) begin
        bits[idx] = tx_v[k];
        idx++;
      end
      if (done_v[k]) begin
        seen = 1'b1;
        break;
      end
      len++;
      step();
    end
    chk1({name, "_done_seen"}, seen, 1'b1);
    chki({name, "_len"}, len + 1, exp_len);
    chki({name, "_bits"}, int'(bits & mask), int'(exp_bits));
    step();
  endtask

  task automatic random_frame(input int k, input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    valid_v[k] = 1'b1;
    data_v[k]  = {1'b0, d};
    step();
    valid_v[k] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_v[k]) begin
        seen = 1'b1;
        break;
      end
      // Noise while busy must be ignored.
      valid_v[k] = ($urandom_range(0, 7) == 0);
      data_v[k]  = 9'($urandom_range(0, 255));
      step();
    end
    valid_v[k] = 1'b0;
    chk1($sformatf("rand[%0d]_done_seen", k), seen, 1'b1);
    step();
  endtask

  initial begin
    int   busy_cycles;
    logic seen;

    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      chk1($sformatf("rst_tx[%0d]", k), tx_v[k], 1'b1);
      chk1($sformatf("rst_ready[%0d]", k), ready_v[k], 1'b1);
      chk1($sformatf("rst_busy[%0d]", k), busy_v[k], 1'b0);
      chk1($sformatf("rst_done[%0d]", k), done_v[k], 1'b0);
    end
    rst_n = 1'b1;
    step();

    send_frame(0, 8'h17, -1, 176, 16'h042E, 11, "a_17");
    send_frame(1, 8'h55, -1, 48, 16'h0EAA, 12, "b_55");
    send_frame(1, 8'hAF, -1, 48, 16'h0F5E, 12, "b_AF");
    send_frame(2, 8'h0F, -1, 160, 16'h021E, 10, "c_0F");

    // Busy protection: 0xFF offered mid-frame is dropped, nothing follows.
    send_frame(0, 8'h17, 40, 176, 16'h042E, 11, "a_busy");
    busy_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy_v[0]) busy_cycles++;
      step();
    end
    chki("a_busy_no_second_frame", busy_cycles, 0);

    // Back-to-back with valid held; data changes after the handshake.
    valid_v[0] = 1'b1;
    data_v[0]  = 9'h0A9;
    step();
    data_v[0] = 9'h0BD;
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_v[0]) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk1("b2b_first_done", seen, 1'b1);
    step();
    chk1("b2b_ready_after_done", ready_v[0], 1'b1);
    step();
    valid_v[0] = 1'b0;
    chk1("b2b_second_start", tx_v[0], 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_v[0]) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk1("b2b_second_done", seen, 1'b1);
    step();

    for (int n = 0; n < 18; n++) begin
      random_frame($urandom_range(0, 2), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset during data bit 3 of instance 0.
    valid_v[0] = 1'b1;
    data_v[0]  = 9'h017;
    step();
    valid_v[0] = 1'b0;
    repeat (72) step();
    chk1("pre_rst_busy", busy_v[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_tx", tx_v[0], 1'b1);
    chk1("rst_mid_busy", busy_v[0], 1'b0);
    chk1("rst_mid_ready", ready_v[0], 1'b1);
    chk1("rst_mid_done", done_v[0], 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    send_frame(0, 8'h0F, -1, 176, 16'h041E, 11, "a_0F_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
